// File: rtl/imem_load_pkg.sv
// Shared constants for the instruction-memory load path: FSM encoding and frame sizes.
// The pad wrapper and the testbench import the same package.
package imem_load_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 40;
  localparam int ADDR_BYTES     = 2;
  localparam int DATA_BYTES_DEF = DATA_WIDTH_DEF / 8;
  localparam int SYNC_BITS      = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ADDR_HI = ST_ADDR_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_DATA    = ST_DATA,
    S_WRITE   = ST_WRITE
  } load_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Instruction-memory write port bundle driven by the load sequencer.
interface imem_load_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 40
);
  logic [ADDR_WIDTH-1:0] imem_write_adr;
  logic [DATA_WIDTH-1:0] imem_in;
  logic                  imem_write_en;

  modport master (output imem_write_adr, output imem_in, output imem_write_en);
  modport slave  (input  imem_write_adr, input  imem_in, input  imem_write_en);
endinterface

// File: rtl/imem_load_ctrl_sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_int,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// MEMLOAD sequencer: synchronises the pad byte interface, assembles address/data
// frames and issues single-cycle imem writes with optional auto-increment bursts.
//
// state    | meaning
// IDLE     | not in MEMLOAD mode, outputs hold
// ADDR_HI  | waiting for address high byte (only low bits used)
// ADDR_LO  | waiting for address low byte
// DATA     | shifting in data bytes, MSB first
// WRITE    | one-cycle write pulse, then burst or new header
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic              clk_int,
  input  logic              reset_n,
  input  logic              mode_memload,
  input  logic              byte_clk,
  input  logic              byte_stream,
  input  logic [7:0]        byte_in,
  imem_load_ctrl_if.master  imem,
  output logic              load_busy,
  output logic              load_error,
  output logic              addr_wrapped,
  output logic [15:0]       word_count
);
  localparam int CNT_W = $clog2(DATA_BYTES + 1);

  logic [SYNC_BITS-1:0]  sync_q;
  logic                  bclk_s;
  logic                  stream_s;
  logic [7:0]            byte_s;
  logic                  bclk_d;
  logic                  byte_stb;

  load_state_e           state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [CNT_W-1:0]      byte_cnt;
  logic                  in_burst_q;
  logic [ADDR_WIDTH-1:0] wr_adr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic clr_sticky, set_err, cap_hi, cap_lo, cap_data, load_word, do_write, do_inc;

  sync_2ff #(.WIDTH(SYNC_BITS)) u_sync (
    .clk_int (clk_int),
    .reset_n (reset_n),
    .d       ({byte_clk, byte_stream, byte_in}),
    .q       (sync_q)
  );

  assign bclk_s   = sync_q[9];
  assign stream_s = sync_q[8];
  assign byte_s   = sync_q[7:0];

  // One strobe per rising edge regardless of how long byte_clk stays high.
  assign byte_stb = bclk_s & ~bclk_d & mode_memload;

  always_comb begin
    state_nxt  = state_q;
    clr_sticky = 1'b0;
    set_err    = 1'b0;
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    cap_data   = 1'b0;
    load_word  = 1'b0;
    do_write   = 1'b0;
    do_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode_memload) begin
          state_nxt  = S_ADDR_HI;
          clr_sticky = 1'b1;
        end
      end
      S_ADDR_HI: begin
        if (!mode_memload) begin
          state_nxt = S_IDLE;
          set_err   = in_burst_q;
        end else if (byte_stb) begin
          cap_hi    = 1'b1;
          state_nxt = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (!mode_memload) begin
          state_nxt = S_IDLE;
          set_err   = 1'b1;
        end else if (byte_stb) begin
          cap_lo    = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (!mode_memload) begin
          state_nxt = S_IDLE;
          set_err   = 1'b1;
        end else if (byte_stb) begin
          cap_data = 1'b1;
          if (byte_cnt == CNT_W'(DATA_BYTES - 1)) begin
            load_word = 1'b1;
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        do_write = 1'b1;
        if (!mode_memload) begin
          state_nxt = S_IDLE;
        end else if (stream_s) begin
          do_inc    = 1'b1;
          state_nxt = S_DATA;
        end else begin
          state_nxt = S_ADDR_HI;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bclk_d       <= 1'b0;
      addr_q       <= '0;
      data_sr      <= '0;
      byte_cnt     <= '0;
      in_burst_q   <= 1'b0;
      wr_adr_q     <= '0;
      wr_data_q    <= '0;
      load_error   <= 1'b0;
      addr_wrapped <= 1'b0;
      word_count   <= '0;
    end else begin
      state_q <= state_nxt;
      bclk_d  <= bclk_s;

      if (clr_sticky) begin
        load_error   <= 1'b0;
        addr_wrapped <= 1'b0;
        word_count   <= '0;
      end
      if (set_err)
        load_error <= 1'b1;

      if (cap_hi)
        addr_q[ADDR_WIDTH-1:8] <= byte_s[ADDR_WIDTH-9:0];
      if (cap_lo)
        addr_q[7:0] <= byte_s;

      if (cap_lo || do_write)
        byte_cnt <= '0;
      else if (cap_data)
        byte_cnt <= byte_cnt + CNT_W'(1);

      if (cap_data)
        data_sr <= DATA_WIDTH'({data_sr, byte_s});

      // Output copies only change on a completed word, so the write port is
      // steady across the pulse and the following burst address bump.
      if (load_word) begin
        wr_adr_q  <= addr_q;
        wr_data_q <= DATA_WIDTH'({data_sr, byte_s});
      end

      if (do_write)
        word_count <= sat_inc16(word_count);

      if (do_inc) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (&addr_q)
          addr_wrapped <= 1'b1;
      end

      if (state_q == S_IDLE || cap_hi)
        in_burst_q <= 1'b0;
      else if (do_inc)
        in_burst_q <= 1'b1;
    end
  end

  assign imem.imem_write_adr = wr_adr_q;
  assign imem.imem_in        = wr_data_q;
  assign imem.imem_write_en  = (state_q == S_WRITE);
  assign load_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: single word, streamed wrap, abort, reset, long strobe, gating.
module tb_imem_load_ctrl;
  import imem_load_pkg::*;

  logic        clk_int = 1'b0;
  logic        reset_n;
  logic        mode_memload;
  logic        byte_clk;
  logic        byte_stream;
  logic [7:0]  byte_in;
  logic        load_busy, load_error, addr_wrapped;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  wr_adr_log[$];
  logic [39:0] wr_dat_log[$];
  int          run_len = 0;
  int          max_run = 0;

  imem_load_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(40)) imem_bus ();

  imem_load_ctrl dut (
    .clk_int      (clk_int),
    .reset_n      (reset_n),
    .mode_memload (mode_memload),
    .byte_clk     (byte_clk),
    .byte_stream  (byte_stream),
    .byte_in      (byte_in),
    .imem         (imem_bus),
    .load_busy    (load_busy),
    .load_error   (load_error),
    .addr_wrapped (addr_wrapped),
    .word_count   (word_count)
  );

  always #5 clk_int = ~clk_int;

  always @(negedge clk_int) begin
    if (imem_bus.imem_write_en === 1'b1) begin
      wr_adr_log.push_back(imem_bus.imem_write_adr);
      wr_dat_log.push_back(imem_bus.imem_in);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_int);
    #2;
  endtask

  task automatic send_byte_hold(input logic [7:0] b, input int high_cycles);
    byte_in = b;
    cyc(3);
    byte_clk = 1'b1;
    cyc(high_cycles);
    byte_clk = 1'b0;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_hold(b, 4);
  endtask

  initial begin
    reset_n      = 1'b0;
    mode_memload = 1'b0;
    byte_clk     = 1'b0;
    byte_stream  = 1'b0;
    byte_in      = 8'h00;
    cyc(3);
    chk("rst_adr",   64'(imem_bus.imem_write_adr), 64'h0);
    chk("rst_data",  64'(imem_bus.imem_in), 64'h0);
    chk("rst_en",    64'(imem_bus.imem_write_en), 64'h0);
    chk("rst_busy",  64'(load_busy), 64'h0);
    chk("rst_err",   64'(load_error), 64'h0);
    chk("rst_wrap",  64'(addr_wrapped), 64'h0);
    chk("rst_wc",    64'(word_count), 64'h0);
    reset_n = 1'b1;
    cyc(2);

    // mode gating
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("gate_busy",  64'(load_busy), 64'h0);
    chk("gate_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("gate_nwr",   64'(wr_adr_log.size()), 64'd0);

    // single word
    mode_memload = 1'b1;
    cyc(2);
    chk("sw_busy", 64'(load_busy), 64'h1);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    chk("sw_nwr",   64'(wr_adr_log.size()), 64'd1);
    chk("sw_adr",   64'(wr_adr_log[0]), 64'h155);
    chk("sw_data",  64'(wr_dat_log[0]), 64'h12_3456_789A);
    chk("sw_wc",    64'(word_count), 64'd1);
    chk("sw_state", 64'(dut.state_q), 64'(ST_ADDR_HI));
    chk("sw_hold",  64'(imem_bus.imem_write_adr), 64'h155);

    // streamed burst wrapping past the top address
    byte_stream = 1'b1;
    send_byte(8'h03);
    send_byte(8'hFE);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    chk("st_wrap0", 64'(addr_wrapped), 64'h0);
    send_byte(8'h11); send_byte(8'h12); send_byte(8'h13); send_byte(8'h14); send_byte(8'h15);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24); send_byte(8'h25);
    chk("st_nwr",   64'(wr_adr_log.size()), 64'd4);
    chk("st_adr1",  64'(wr_adr_log[1]), 64'h3FE);
    chk("st_adr2",  64'(wr_adr_log[2]), 64'h3FF);
    chk("st_adr3",  64'(wr_adr_log[3]), 64'h000);
    chk("st_dat1",  64'(wr_dat_log[1]), 64'h01_0203_0405);
    chk("st_dat3",  64'(wr_dat_log[3]), 64'h21_2223_2425);
    chk("st_wrap",  64'(addr_wrapped), 64'h1);
    chk("st_wc",    64'(word_count), 64'd4);
    chk("st_state", 64'(dut.state_q), 64'(ST_DATA));

    // abort after 3 data bytes
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    mode_memload = 1'b0;
    cyc(3);
    chk("ab_nwr",   64'(wr_adr_log.size()), 64'd4);
    chk("ab_err",   64'(load_error), 64'h1);
    chk("ab_busy",  64'(load_busy), 64'h0);
    chk("ab_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("ab_wrap",  64'(addr_wrapped), 64'h1);
    chk("ab_adr",   64'(imem_bus.imem_write_adr), 64'h000);

    // re-entry clears sticky flags
    byte_stream  = 1'b0;
    mode_memload = 1'b1;
    cyc(2);
    chk("clr_err",  64'(load_error), 64'h0);
    chk("clr_wrap", 64'(addr_wrapped), 64'h0);
    chk("clr_wc",   64'(word_count), 64'd0);
    chk("clr_busy", 64'(load_busy), 64'h1);

    send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    chk("f2_adr", 64'(wr_adr_log[4]), 64'h010);
    chk("f2_dat", 64'(wr_dat_log[4]), 64'hAA_BBCC_DDEE);
    chk("f2_wc",  64'(word_count), 64'd1);

    // reset in the middle of a frame
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h01); send_byte(8'h02);
    chk("mr_state", 64'(dut.state_q), 64'(ST_DATA));
    reset_n = 1'b0;
    #1;
    chk("mr_adr",  64'(imem_bus.imem_write_adr), 64'h0);
    chk("mr_data", 64'(imem_bus.imem_in), 64'h0);
    chk("mr_en",   64'(imem_bus.imem_write_en), 64'h0);
    chk("mr_busy", 64'(load_busy), 64'h0);
    chk("mr_wc",   64'(word_count), 64'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("mr_busy2", 64'(load_busy), 64'h1);
    send_byte(8'h01); send_byte(8'h23);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE); send_byte(8'h01);
    chk("mr_nwr", 64'(wr_adr_log.size()), 64'd6);
    chk("mr_adr2", 64'(wr_adr_log[5]), 64'h123);
    chk("mr_dat2", 64'(wr_dat_log[5]), 64'hCA_FEBA_BE01);
    chk("mr_wc2",  64'(word_count), 64'd1);

    // long strobe with ignored high address bits
    send_byte_hold(8'hFF, 20);
    chk("ls_state", 64'(dut.state_q), 64'(ST_ADDR_LO));
    send_byte(8'h07);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    chk("ls_nwr", 64'(wr_adr_log.size()), 64'd7);
    chk("ls_adr", 64'(wr_adr_log[6]), 64'h307);
    chk("ls_dat", 64'(wr_dat_log[6]), 64'h11_2233_4455);
    chk("ls_wc",  64'(word_count), 64'd2);

    chk("pulse_width", 64'(max_run), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
